// File: rtl/seq_add_sub_64.sv
// seq_add_sub_64: 64-bit add/subtract built from one 32-bit ripple carry
// adder used twice, low word first and high word second. The carry between
// the two words is kept in a flip-flop. Subtract is done as a + ~b + 1.

// rca_32_bit: purely combinational 32-bit ripple carry adder.
module rca_32_bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);

   logic [32:0] carry;

   assign carry[0] = c_in;

   // One full adder per bit; the carry ripples from bit 0 to bit 31.
   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c_out = carry[32];

endmodule

module seq_add_sub_64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op_sub,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] result,
   output logic        c_out,
   output logic        overflow,
   output logic        zero,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [63:0] opa;
   logic [63:0] opb;
   logic        cy;
   logic [31:0] low_sum;

   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_sum;
   logic        add_cout;

   // The single shared adder. In LOW it adds the low halves, in HIGH the high halves.
   rca_32_bit u_rca (
      .a     (add_a),
      .b     (add_b),
      .c_in  (cy),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   // Select which half of the latched operands feeds the adder.
   always_comb begin
      add_a = opa[31:0];
      add_b = opb[31:0];
      if (state == HIGH) begin
         add_a = opa[63:32];
         add_b = opb[63:32];
      end
   end

   // Next-state logic. A start request only matters in IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOW;
         LOW:     state_next = HIGH;
         HIGH:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Datapath registers. Results and flags change only when HIGH completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa      <= '0;
         opb      <= '0;
         cy       <= 1'b0;
         low_sum  <= '0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opa <= a;
                  opb <= op_sub ? ~b : b;
                  cy  <= op_sub;
               end
            end
            LOW: begin
               low_sum <= add_sum;
               cy      <= add_cout;
            end
            HIGH: begin
               result   <= {add_sum, low_sum};
               c_out    <= add_cout;
               overflow <= (opa[63] == opb[63]) && (add_sum[31] != opa[63]);
               zero     <= ({add_sum, low_sum} == 64'd0);
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_add_sub_64.sv
// Testbench for seq_add_sub_64: directed vectors with hand-computed results,
// reset and handshake cases, then random operations against a 65-bit model.
module tb_seq_add_sub_64;

   logic        clk;
   logic        rst;
   logic        start;
   logic        op_sub;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] result;
   logic        c_out;
   logic        overflow;
   logic        zero;
   logic        busy;
   logic        done;

   int vectors     = 0;
   int miscompares = 0;

   seq_add_sub_64 dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow),
      .zero     (zero),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present operands with start for one rising edge, then drop start.
   task automatic applyStimulus(input logic [63:0] va, input logic [63:0] vb, input logic vsub);
      a      = va;
      b      = vb;
      op_sub = vsub;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Count rising edges until done is seen, bounded so the bench cannot hang.
   task automatic waitDone(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 8);
      if (!done) checkOutput("done_timeout", {63'd0, done}, 64'd1);
   endtask

   // One operation with hand-computed expected result and flags.
   task automatic runDirected(input string tag, input logic [63:0] va, input logic [63:0] vb,
                              input logic vsub, input logic [63:0] er, input logic ec,
                              input logic ev, input logic ez);
      int n;
      applyStimulus(va, vb, vsub);
      checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd1);
      waitDone(n);
      checkOutput({tag, "_latency"}, 64'(n), 64'd2);
      checkOutput({tag, "_result"}, result, er);
      checkOutput({tag, "_c_out"}, {63'd0, c_out}, {63'd0, ec});
      checkOutput({tag, "_overflow"}, {63'd0, overflow}, {63'd0, ev});
      checkOutput({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
      checkOutput({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int          n;
      logic        saw_done;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;
      logic [64:0] full;
      logic [63:0] er;
      logic        ev;

      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      #12;

      // Outputs while reset is held.
      checkOutput("reset_result", result, 64'd0);
      checkOutput("reset_zero", {63'd0, zero}, 64'd0);
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_done", {63'd0, done}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Carry crosses from the low word into the high word.
      runDirected("cross_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
                  64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of LOW aborts the operation.
      applyStimulus(64'h1, 64'h1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midreset_result", result, 64'd0);
      checkOutput("midreset_c_out", {63'd0, c_out}, 64'd0);
      checkOutput("midreset_overflow", {63'd0, overflow}, 64'd0);
      checkOutput("midreset_zero", {63'd0, zero}, 64'd0);
      checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
      checkOutput("midreset_done", {63'd0, done}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done;
      end
      checkOutput("midreset_no_done", {63'd0, saw_done}, 64'd0);
      checkOutput("midreset_idle", {63'd0, busy}, 64'd0);

      // Full 64-bit wrap to zero.
      runDirected("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                  64'h0, 1'b1, 1'b0, 1'b1);

      // Signed overflow on add.
      runDirected("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

      // Subtract with borrow, then subtract with signed overflow.
      runDirected("sub_borrow", 64'd5, 64'd7, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      runDirected("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Start pulsed during LOW with other operands must be ignored.
      applyStimulus(64'd10, 64'd20, 1'b0);
      a      = 64'd999;
      b      = 64'd999;
      op_sub = 1'b1;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      waitDone(n);
      checkOutput("ignore_latency", 64'(n), 64'd1);
      checkOutput("ignore_result", result, 64'd30);
      @(posedge clk);
      #1;
      checkOutput("ignore_not_queued_done", {63'd0, done}, 64'd0);
      checkOutput("ignore_not_queued_busy", {63'd0, busy}, 64'd0);

      // Start raised in the done cycle is accepted; next done 3 edges later.
      runDirected("b2b_first", 64'd100, 64'd1, 1'b1, 64'd99, 1'b1, 1'b0, 1'b0);
      applyStimulus(64'd3, 64'd4, 1'b0);
      waitDone(n);
      checkOutput("b2b_latency", 64'(n + 1), 64'd3);
      checkOutput("b2b_result", result, 64'd7);

      // Random operations against a 65-bit reference.
      for (int i = 0; i < 1000; i++) begin
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rs   = 1'($urandom_range(0, 1));
         full = rs ? ({1'b0, ra} - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
         er   = full[63:0];
         if (rs) ev = (ra[63] != rb[63]) && (er[63] != ra[63]);
         else    ev = (ra[63] == rb[63]) && (er[63] != ra[63]);
         // For subtract the carry is the inverse of the borrow.
         runDirected("random", ra, rb, rs, er, rs ? ~full[64] : full[64], ev, er == 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
